osc_prog_seq: RTL and testbench

APB master sequencer that safely reprograms one of the two clock oscillator registers in the APB register peripheral. It executes the full protected sequence: unlock with key, write the oscillator value, optionally read it back to verify, then relock. It sits between a local requester (boot logic or a debug port) and a dedicated APB port of that peripheral. It removes lock-key handling from software.

---
 rtl/apb_regs_pkg.sv | 33 +++
 rtl/osc_prog_apb_xfer.sv | 55 +++++
 rtl/osc_prog_seq.sv | 169 ++++++++++++++++
 tb/tb_osc_prog_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_regs_pkg.sv
// Shared constants for the APB register peripheral and the oscillator
// programming sequencer (address map, lock key, sequencer state encoding).
package apb_regs_pkg;

  localparam int unsigned OSC_W  = 19;
  localparam int unsigned PA_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RTRY_W = 4;

  localparam logic [PA_W-1:0] LM_OSC1 = 3'b000;
  localparam logic [PA_W-1:0] LM_OSC2 = 3'b001;
  localparam logic [PA_W-1:0] LM_LOCK = 3'b010;
  localparam logic [PA_W-1:0] LM_LEDS = 3'b011;
  localparam logic [PA_W-1:0] LM_INT  = 3'b100;
  localparam logic [PA_W-1:0] LM_SW   = 3'b101;

  localparam logic [15:0] LOCK_KEY = 16'hA05F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNLOCK = 3'd1,
    ST_OSCWR  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_RELOCK = 3'd4,
    ST_FIN    = 3'd5
  } osc_seq_state_e;

  // Oscillator register address for a given select bit.
  function automatic logic [PA_W-1:0] osc_addr(input logic sel);
    return sel ? LM_OSC2 : LM_OSC1;
  endfunction

endpackage

// File: rtl/osc_prog_apb_xfer.sv
// Two-phase (SETUP/ACCESS) APB transfer engine with no PREADY.
// A start accepted in the last ACCESS cycle launches the next SETUP directly,
// giving back-to-back transfers.
module osc_prog_apb_xfer
  import apb_regs_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_write,
  input  logic [PA_W-1:0]   i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_prdata,
  output logic              o_done_c,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [PA_W-1:0]   o_pa,
  output logic [DATA_W-1:0] o_pwdata
);

  // Transfer completes at the end of the ACCESS cycle.
  assign o_done_c = o_psel & o_penable;

  // APB phase sequencing, bus output registers and read-data capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_psel    <= 1'b0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_pa      <= '0;
      o_pwdata  <= '0;
      o_rdata   <= '0;
    end else begin
      if (i_start) begin
        o_psel    <= 1'b1;
        o_penable <= 1'b0;
        o_pwrite  <= i_write;
        o_pa      <= i_addr;
        o_pwdata  <= i_write ? i_wdata : '0;
      end else if (o_psel && !o_penable) begin
        o_penable <= 1'b1;
      end else begin
        o_psel    <= 1'b0;
        o_penable <= 1'b0;
        o_pwrite  <= 1'b0;
        o_pa      <= '0;
        o_pwdata  <= '0;
      end
      if (o_done_c) o_rdata <= i_prdata;
    end
  end

endmodule

// File: rtl/osc_prog_seq.sv
// Oscillator reprogramming sequencer: unlock, write oscillator, optional
// read-back verify with retries, relock. Build macro OSC_PROG_VERIFY_EN
// compiles in the VERIFY state, retry counter and ERR logic.
module osc_prog_seq
  import apb_regs_pkg::*;
#(
  parameter int unsigned VERIFY_RETRIES = 1
) (
  input  logic              PCLK,
  input  logic              nRESET,
  input  logic              REQ,
  input  logic              OSCSEL,
  input  logic [OSC_W-1:0]  OSCVAL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [PA_W-1:0]   PA,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA
);

  osc_seq_state_e    r_state;
  osc_seq_state_e    w_next;
  logic              r_sel;
  logic [OSC_W-1:0]  r_val;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_start;
  logic              w_write;
  logic [PA_W-1:0]   w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_xfer_done;
  logic [DATA_W-1:0] w_rdata;
  logic [PA_W-1:0]   w_osc_addr;
  logic              w_unused;

  assign w_osc_addr = osc_addr(r_sel);
  assign BUSY       = r_busy;
  assign DONE       = r_done;

`ifdef OSC_PROG_VERIFY_EN
  logic [RTRY_W-1:0] r_retry;
  logic              r_err;
  logic              w_match;
  logic              w_retry_ok;

  // PRDATA is compared in the ACCESS cycle so the next transfer can start back-to-back.
  assign w_match    = (PRDATA == DATA_W'(r_val));
  assign w_retry_ok = (r_retry < RTRY_W'(VERIFY_RETRIES));
  assign ERR        = r_err;
  assign w_unused   = ^w_rdata;
`else
  assign ERR        = 1'b0;
  assign w_unused   = ^{w_rdata, RTRY_W'(VERIFY_RETRIES)};
`endif

  // Next state and the transfer to launch when the current one finishes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_write  = 1'b1;
    w_addr   = LM_LOCK;
    w_wdata  = '0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        w_next = ST_IDLE;
        if (REQ) begin
          w_accept = 1'b1;
          w_start  = 1'b1;
          w_wdata  = DATA_W'(LOCK_KEY);
          w_next   = ST_UNLOCK;
        end
      end
      ST_UNLOCK: begin
        if (w_xfer_done) begin
          w_start = 1'b1;
          w_addr  = w_osc_addr;
          w_wdata = DATA_W'(r_val);
          w_next  = ST_OSCWR;
        end
      end
      ST_OSCWR: begin
        if (w_xfer_done) begin
          w_start = 1'b1;
`ifdef OSC_PROG_VERIFY_EN
          w_write = 1'b0;
          w_addr  = w_osc_addr;
          w_next  = ST_VERIFY;
`else
          w_next  = ST_RELOCK;
`endif
        end
      end
`ifdef OSC_PROG_VERIFY_EN
      ST_VERIFY: begin
        if (w_xfer_done) begin
          w_start = 1'b1;
          if (w_match || !w_retry_ok) begin
            w_next = ST_RELOCK;
          end else begin
            w_addr  = w_osc_addr;
            w_wdata = DATA_W'(r_val);
            w_next  = ST_OSCWR;
          end
        end
      end
`endif
      ST_RELOCK: begin
        if (w_xfer_done) w_next = ST_FIN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Sequencer state, captured operands, status outputs and retry/error tracking.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_val   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef OSC_PROG_VERIFY_EN
      r_retry <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE) && (w_next != ST_FIN);
      r_done  <= (w_next == ST_FIN);
      if (w_accept) begin
        r_sel <= OSCSEL;
        r_val <= OSCVAL;
      end
`ifdef OSC_PROG_VERIFY_EN
      if (w_accept) begin
        r_err   <= 1'b0;
        r_retry <= '0;
      end else if (r_state == ST_VERIFY && w_xfer_done && !w_match) begin
        if (w_retry_ok) r_retry <= r_retry + RTRY_W'(1);
        else            r_err   <= 1'b1;
      end
`endif
    end
  end

  osc_prog_apb_xfer u_xfer (
    .i_clk     (PCLK),
    .i_rst_n   (nRESET),
    .i_start   (w_start),
    .i_write   (w_write),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_prdata  (PRDATA),
    .o_done_c  (w_xfer_done),
    .o_rdata   (w_rdata),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_pa      (PA),
    .o_pwdata  (PWDATA)
  );

endmodule

// File: tb/tb_osc_prog_seq.sv
// Bench for osc_prog_seq against a small model of the APB register peripheral.
// Expected APB transfers are queued per request and popped at each ACCESS.
module tb_osc_prog_seq;
  import apb_regs_pkg::*;

  localparam int unsigned RETRIES = 1;
`ifdef OSC_PROG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef logic [35:0] xfer_t;

  logic        PCLK = 1'b0;
  logic        nRESET;
  logic        REQ;
  logic        OSCSEL;
  logic [18:0] OSCVAL;
  logic        BUSY, DONE, ERR;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PA;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  logic [18:0] m_osc1, m_osc2;
  logic        m_locked;
  logic [31:0] m_prdata;
  bit          corrupt = 1'b0;

  xfer_t       sb_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  osc_prog_seq #(.VERIFY_RETRIES(RETRIES)) dut (
    .PCLK(PCLK), .nRESET(nRESET), .REQ(REQ), .OSCSEL(OSCSEL), .OSCVAL(OSCVAL),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PA(PA), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Peripheral model: lockable oscillator registers, PRDATA registered in SETUP.
  assign PRDATA = m_prdata;
  always @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      m_osc1   <= 19'h67C04;
      m_osc2   <= 19'h67C04;
      m_locked <= 1'b1;
      m_prdata <= 32'h0;
    end else begin
      if (PSEL && !PENABLE) begin
        case (PA)
          3'b000:  m_prdata <= {13'h0, m_osc1} ^ (corrupt ? 32'h1 : 32'h0);
          3'b001:  m_prdata <= {13'h0, m_osc2} ^ (corrupt ? 32'h1 : 32'h0);
          3'b010:  m_prdata <= {15'h0, m_locked, 16'h0};
          default: m_prdata <= 32'h0;
        endcase
      end
      if (PSEL && PENABLE && PWRITE) begin
        if (PA == 3'b010)                   m_locked <= (PWDATA[15:0] != 16'hA05F);
        else if (PA == 3'b000 && !m_locked) m_osc1   <= PWDATA[18:0];
        else if (PA == 3'b001 && !m_locked) m_osc2   <= PWDATA[18:0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Scoreboard monitor: SETUP must already show the transfer, ACCESS retires it.
  always @(negedge PCLK) begin
    if (nRESET && PSEL) begin
      if (sb_q.size() == 0)
        check("sb_unexpected_xfer", 64'(PSEL), 64'(0));
      else if (!PENABLE)
        check("apb_setup", 64'({PWRITE, PA, PWDATA}), 64'(sb_q[0]));
      else
        check("apb_access", 64'({PWRITE, PA, PWDATA}), 64'(sb_q.pop_front()));
    end
  end

  task automatic push_seq(input logic sel, input logic [18:0] val, input int att);
    logic [2:0] oa;
    oa = sel ? 3'b001 : 3'b000;
    sb_q.push_back({1'b1, 3'b010, 32'h0000_A05F});
    for (int i = 0; i < att; i++) begin
      sb_q.push_back({1'b1, oa, 13'h0, val});
      if (VERIFY) sb_q.push_back({1'b0, oa, 32'h0});
    end
    sb_q.push_back({1'b1, 3'b010, 32'h0});
  endtask

  task automatic wait_done(inout int n);
    while (!DONE && n < 80) begin
      @(negedge PCLK);
      n++;
    end
    check("done_seen", 64'(DONE), 64'(1));
  endtask

  task automatic run_seq(input logic sel, input logic [18:0] val, input bit bad,
                         input logic exp_err);
    int att;
    int exp_cyc;
    int n;
    att     = (VERIFY && bad) ? int'(RETRIES) + 1 : 1;
    exp_cyc = VERIFY ? 9 + 4 * (att - 1) : 7;
    corrupt = bad;
    push_seq(sel, val, att);
    @(negedge PCLK);
    REQ = 1'b1; OSCSEL = sel; OSCVAL = val;
    @(negedge PCLK);
    n = 1;
    REQ = 1'b0; OSCSEL = ~sel; OSCVAL = ~val;
    check("busy_cycle1", 64'(BUSY), 64'(1));
    check("err_cleared", 64'(ERR), 64'(0));
    wait_done(n);
    check("done_cycle", 64'(n), 64'(exp_cyc));
    check("err_at_done", 64'(ERR), 64'(exp_err));
    check("idle_at_done", 64'({BUSY, PSEL, PWDATA}), 64'(0));
    @(negedge PCLK);
    check("done_one_cycle", 64'(DONE), 64'(0));
    check("err_hold", 64'(ERR), 64'(exp_err));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    corrupt = 1'b0;
  endtask

  initial begin
    int n;
    nRESET = 1'b0; REQ = 1'b0; OSCSEL = 1'b0; OSCVAL = 19'h0;
    repeat (3) @(negedge PCLK);
    nRESET = 1'b1;
    @(negedge PCLK);
    check("reset_outputs",
          64'({PSEL, PENABLE, PWRITE, PA, PWDATA, BUSY, DONE, ERR}), 64'(0));

    // Basic OSC1 programming.
    run_seq(1'b0, 19'h12345, 1'b0, 1'b0);
    check("osc1_written", 64'(m_osc1), 64'(19'h12345));
    check("relocked_1", 64'(m_locked), 64'(1));

    // OSC2 with all-ones value; OSC1 untouched.
    run_seq(1'b1, 19'h7FFFF, 1'b0, 1'b0);
    check("osc2_written", 64'(m_osc2), 64'(19'h7FFFF));
    check("osc1_kept", 64'(m_osc1), 64'(19'h12345));
    check("relocked_2", 64'(m_locked), 64'(1));

    // Forced read-back mismatch, then a clean request clears ERR.
    run_seq(1'b0, 19'h01111, 1'b1, VERIFY);
    check("relocked_after_err", 64'(m_locked), 64'(1));
    run_seq(1'b0, 19'h02222, 1'b0, 1'b0);
    check("osc1_after_err", 64'(m_osc1), 64'(19'h02222));

    // REQ held through completion; OSCVAL changes mid-sequence.
    push_seq(1'b0, 19'h0AAAA, 1);
    push_seq(1'b0, 19'h05555, 1);
    @(negedge PCLK);
    REQ = 1'b1; OSCSEL = 1'b0; OSCVAL = 19'h0AAAA;
    @(negedge PCLK);
    n = 1;
    while (!DONE && n < 80) begin
      @(negedge PCLK);
      n++;
      if (n == 2) OSCVAL = 19'h05555;
    end
    check("b2b_done1_cycle", 64'(n), 64'(VERIFY ? 9 : 7));
    check("b2b_first_val", 64'(m_osc1), 64'(19'h0AAAA));
    @(negedge PCLK);
    check("b2b_next_setup", 64'({PSEL, PENABLE, PA, BUSY}), 64'({1'b1, 1'b0, 3'b010, 1'b1}));
    REQ = 1'b0;
    n = 1;
    wait_done(n);
    check("b2b_done2_cycle", 64'(n), 64'(VERIFY ? 9 : 7));
    check("b2b_second_val", 64'(m_osc1), 64'(19'h05555));
    @(negedge PCLK);
    check("b2b_sb_drained", 64'(sb_q.size()), 64'(0));

    // Reset pulse during the OSCWR ACCESS cycle.
    push_seq(1'b0, 19'h0F0F0, 1);
    @(negedge PCLK);
    REQ = 1'b1; OSCSEL = 1'b0; OSCVAL = 19'h0F0F0;
    @(negedge PCLK);
    REQ = 1'b0;
    repeat (3) @(negedge PCLK);
    check("pre_reset_oscwr_access", 64'({PSEL, PENABLE, PWRITE, PA}), 64'(6'b111_000));
    #1 nRESET = 1'b0;
    #1 check("mid_reset_outputs",
             64'({PSEL, PENABLE, PWRITE, PA, PWDATA, BUSY, DONE, ERR}), 64'(0));
    sb_q.delete();
    @(negedge PCLK);
    nRESET = 1'b1;
    @(negedge PCLK);
    run_seq(1'b1, 19'h3C3C3, 1'b0, 1'b0);
    check("osc2_after_reset", 64'(m_osc2), 64'(19'h3C3C3));
    check("relocked_after_reset", 64'(m_locked), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
